// File: rtl/ifetch_stage.sv
// Instruction fetch stage: issues word fetches to instruction memory and pushes
// {instr, pc, pc+4} packets to the decode FIFO, handling redirects and backpressure.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned FIFO_W   = 96
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              pushing,
  output logic [FIFO_W-1:0] out_data,
  input  logic              push_must_wait,
  output logic [31:0]       fetch_count,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {StHalt, StReq, StPush, StDrain} state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       addr_q;
  logic              req_q;
  logic              push_q;
  logic [FIFO_W-1:0] data_q;
  logic [31:0]       fetch_cnt_q;
  logic [15:0]       drop_cnt_q;

  logic [31:0] redir_pc;
  logic [31:0] pc_inc;
  logic [31:0] accept_pc;
  logic [15:0] drop_inc;

  always_comb begin
    redir_pc  = redirect_pc & 32'hFFFF_FFFC;
    pc_inc    = pc_q + 32'd4;
    accept_pc = redirect_valid ? redir_pc : pc_inc;
    drop_inc  = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StHalt;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      req_q       <= 1'b0;
      push_q      <= 1'b0;
      data_q      <= '0;
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StHalt: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
          end else if (!halt) begin
            state_q <= StReq;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end

        StReq: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
            if (imem_ack) begin
              // Response belongs to the stale path; reissue at the target now.
              drop_cnt_q <= drop_inc;
              addr_q     <= redir_pc;
            end else begin
              state_q <= StDrain;
            end
          end else if (imem_ack) begin
            data_q  <= {imem_rdata, pc_q, pc_inc};
            state_q <= StPush;
            req_q   <= 1'b0;
            push_q  <= 1'b1;
          end
        end

        StPush: begin
          if (!push_must_wait) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            pc_q        <= accept_pc;
            push_q      <= 1'b0;
            if (halt) begin
              state_q <= StHalt;
            end else begin
              state_q <= StReq;
              req_q   <= 1'b1;
              addr_q  <= accept_pc;
            end
          end else if (redirect_valid) begin
            pc_q    <= redir_pc;
            state_q <= StReq;
            push_q  <= 1'b0;
            req_q   <= 1'b1;
            addr_q  <= redir_pc;
          end
        end

        StDrain: begin
          // The outstanding request keeps its original address until acked.
          if (redirect_valid) begin
            pc_q <= redir_pc;
          end
          if (imem_ack) begin
            drop_cnt_q <= drop_inc;
            state_q    <= StReq;
            addr_q     <= redirect_valid ? redir_pc : pc_q;
          end
        end

        default: begin
          state_q <= StHalt;
          req_q   <= 1'b0;
          push_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pushing     = push_q;
  assign out_data    = data_q;
  assign fetch_count = fetch_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a latency-programmable memory model
// that returns addr ^ 32'hA5A5_A5A5.
module tb_ifetch_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pushing;
  logic [95:0] out_data;
  logic        push_must_wait;
  logic [31:0] fetch_count;
  logic [15:0] drop_count;

  int unsigned mem_lat;
  int unsigned lat_cnt;
  int          passed;
  int          total;

  ifetch_stage #(
    .RESET_PC(32'h0040_0000),
    .FIFO_W  (96)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pushing       (pushing),
    .out_data      (out_data),
    .push_must_wait(push_must_wait),
    .fetch_count   (fetch_count),
    .drop_count    (drop_count)
  );

  always #5 CLK = ~CLK;

  // Ack after mem_lat cycles of an outstanding request (0 = same cycle).
  always @(posedge CLK) begin
    if (RESET || !imem_req || imem_ack) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end
  assign imem_ack   = imem_req && (lat_cnt >= mem_lat);
  assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

  function automatic logic [95:0] pkt(input logic [31:0] a);
    return {a ^ 32'hA5A5_A5A5, a, a + 32'd4};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; halt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    push_must_wait = 1'b0; mem_lat = 0;
    tick(); tick();
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passed++;
    total++; if (pushing !== 1'b0) $display("FAIL reset_push: got %b want 0", pushing); else passed++;
    total++; if (out_data !== 96'd0) $display("FAIL reset_data: got %h want 0", out_data); else passed++;
    total++; if (fetch_count !== 32'd0) $display("FAIL reset_fetch: got %0d want 0", fetch_count); else passed++;
    total++; if (drop_count !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_count); else passed++;
  endtask

  task automatic test_reset_exit();
    RESET = 1'b0; halt = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL exit_req: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0040_0000) $display("FAIL exit_addr: got %h want 00400000", imem_addr); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] a;
    a = 32'h0040_0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (pushing !== 1'b1) $display("FAIL stream_push%0d: got %b want 1", k, pushing); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL stream_req_lo%0d: got %b want 0", k, imem_req); else passed++;
      total++; if (out_data !== pkt(a)) $display("FAIL stream_data%0d: got %h want %h", k, out_data, pkt(a)); else passed++;
      tick();
      total++; if (fetch_count !== 32'(k)) $display("FAIL stream_fetch%0d: got %0d want %0d", k, fetch_count, k); else passed++;
      total++; if (imem_req !== 1'b1) $display("FAIL stream_req%0d: got %b want 1", k, imem_req); else passed++;
      total++; if (imem_addr !== a + 32'd4) $display("FAIL stream_addr%0d: got %h want %h", k, imem_addr, a + 32'd4); else passed++;
      total++; if (pushing !== 1'b0) $display("FAIL stream_push_lo%0d: got %b want 0", k, pushing); else passed++;
      a = a + 32'd4;
    end
  endtask

  task automatic test_backpressure();
    push_must_wait = 1'b1;
    tick();
    for (int i = 0; i <= 5; i++) begin
      total++; if (pushing !== 1'b1) $display("FAIL bp_push%0d: got %b want 1", i, pushing); else passed++;
      total++; if (out_data !== pkt(32'h0040_000C)) $display("FAIL bp_data%0d: got %h want %h", i, out_data, pkt(32'h0040_000C)); else passed++;
      total++; if (fetch_count !== 32'd3) $display("FAIL bp_fetch%0d: got %0d want 3", i, fetch_count); else passed++;
      if (i == 5) push_must_wait = 1'b0;
      tick();
    end
    total++; if (fetch_count !== 32'd4) $display("FAIL bp_accept: got %0d want 4", fetch_count); else passed++;
    total++; if (imem_addr !== 32'h0040_0010) $display("FAIL bp_addr: got %h want 00400010", imem_addr); else passed++;
    total++; if (pushing !== 1'b0) $display("FAIL bp_push_lo: got %b want 0", pushing); else passed++;
  endtask

  task automatic test_redirect_drain();
    mem_lat = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b1) $display("FAIL drain_req%0d: got %b want 1", i, imem_req); else passed++;
      total++; if (imem_addr !== 32'h0040_0010) $display("FAIL drain_addr%0d: got %h want 00400010", i, imem_addr); else passed++;
      total++; if (pushing !== 1'b0) $display("FAIL drain_push%0d: got %b want 0", i, pushing); else passed++;
      tick();
    end
    total++; if (drop_count !== 16'd1) $display("FAIL drain_drop: got %0d want 1", drop_count); else passed++;
    total++; if (imem_addr !== 32'h0040_0100) $display("FAIL drain_newaddr: got %h want 00400100", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL drain_newreq: got %b want 1", imem_req); else passed++;
    total++; if (fetch_count !== 32'd4) $display("FAIL drain_fetch: got %0d want 4", fetch_count); else passed++;
  endtask

  task automatic test_redirect_push();
    mem_lat = 0;
    push_must_wait = 1'b1;
    tick();
    total++; if (pushing !== 1'b1) $display("FAIL rpush_push: got %b want 1", pushing); else passed++;
    total++; if (out_data !== pkt(32'h0040_0100)) $display("FAIL rpush_data: got %h want %h", out_data, pkt(32'h0040_0100)); else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0202;
    tick();
    redirect_valid = 1'b0; push_must_wait = 1'b0;
    total++; if (pushing !== 1'b0) $display("FAIL rpush_drop: got %b want 0", pushing); else passed++;
    total++; if (fetch_count !== 32'd4) $display("FAIL rpush_fetch: got %0d want 4", fetch_count); else passed++;
    total++; if (drop_count !== 16'd1) $display("FAIL rpush_dropcnt: got %0d want 1", drop_count); else passed++;
    total++; if (imem_addr !== 32'h0040_0200) $display("FAIL rpush_addr: got %h want 00400200", imem_addr); else passed++;
  endtask

  task automatic test_wrap_halt();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); else passed++;
    total++; if (drop_count !== 16'd2) $display("FAIL wrap_drop: got %0d want 2", drop_count); else passed++;
    total++; if (pushing !== 1'b0) $display("FAIL wrap_nopush: got %b want 0", pushing); else passed++;
    tick();
    halt = 1'b1;
    total++; if (out_data !== pkt(32'hFFFF_FFFC)) $display("FAIL wrap_data: got %h want %h", out_data, pkt(32'hFFFF_FFFC)); else passed++;
    total++; if (out_data[31:0] !== 32'd0) $display("FAIL wrap_inc: got %h want 0", out_data[31:0]); else passed++;
    tick();
    total++; if (fetch_count !== 32'd5) $display("FAIL wrap_fetch: got %0d want 5", fetch_count); else passed++;
    total++; if (pushing !== 1'b0) $display("FAIL halt_push: got %b want 0", pushing); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b0) $display("FAIL halt_req%0d: got %b want 0", i, imem_req); else passed++;
      tick();
    end
    total++; if (out_data !== pkt(32'hFFFF_FFFC)) $display("FAIL halt_hold: got %h want %h", out_data, pkt(32'hFFFF_FFFC)); else passed++;
    halt = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL unhalt_req: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'd0) $display("FAIL unhalt_addr: got %h want 0", imem_addr); else passed++;
  endtask

  task automatic test_drain_retarget();
    mem_lat = 2;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    tick();
    total++; if (imem_addr !== 32'd0) $display("FAIL retgt_hold: got %h want 0", imem_addr); else passed++;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'd0) $display("FAIL retgt_hold2: got %h want 0", imem_addr); else passed++;
    total++; if (drop_count !== 16'd2) $display("FAIL retgt_nodrop: got %0d want 2", drop_count); else passed++;
    tick();
    total++; if (drop_count !== 16'd3) $display("FAIL retgt_drop: got %0d want 3", drop_count); else passed++;
    total++; if (imem_addr !== 32'h0000_2000) $display("FAIL retgt_addr: got %h want 00002000", imem_addr); else passed++;
  endtask

  task automatic test_reset_in_drain();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'h0000_2000) $display("FAIL rdrain_hold: got %h want 00002000", imem_addr); else passed++;
    RESET = 1'b1;
    tick();
    total++; if (imem_req !== 1'b0) $display("FAIL rdrain_req: got %b want 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'd0) $display("FAIL rdrain_addr: got %h want 0", imem_addr); else passed++;
    total++; if (pushing !== 1'b0) $display("FAIL rdrain_push: got %b want 0", pushing); else passed++;
    total++; if (out_data !== 96'd0) $display("FAIL rdrain_data: got %h want 0", out_data); else passed++;
    total++; if (fetch_count !== 32'd0) $display("FAIL rdrain_fetch: got %0d want 0", fetch_count); else passed++;
    total++; if (drop_count !== 16'd0) $display("FAIL rdrain_dropcnt: got %0d want 0", drop_count); else passed++;
    RESET = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL rdrain_restart: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0040_0000) $display("FAIL rdrain_pc: got %h want 00400000", imem_addr); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_reset_exit();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_push();
    test_wrap_halt();
    test_drain_retarget();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
